// File: rtl/ahb_slave_if_if.sv
`default_nettype none
// ============================================================================
// Module      : ahb_slave_if_if
// Description : AHB-Lite bus bundle between an AHB master (or bus fabric)
//               and the AHB slave front end of the AHB-to-APB bridge.
//               master modport : drives hready_in/htrans/hwrite/haddr/hwdata,
//                                observes the pipeline, select and response.
//               slave modport  : the reverse.
// Revision    : 1.0  initial release
// ============================================================================
interface ahb_slave_if_if;
    // AHB inputs to the slave front end
    logic        hready_in;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [31:0] haddr;
    logic [31:0] hwdata;

    // Front-end outputs toward the bridge FSM and the AHB response mux
    logic        valid;
    logic [31:0] haddr_0;
    logic [31:0] haddr_1;
    logic [31:0] hwdata_0;
    logic [31:0] hwdata_1;
    logic        hwrite_reg;
    logic        hwrite_reg_1;
    logic [2:0]  temp_sel;
    logic [1:0]  err_resp;
    logic        err_ready;

    modport master (
        output hready_in, htrans, hwrite, haddr, hwdata,
        input  valid, haddr_0, haddr_1, hwdata_0, hwdata_1,
               hwrite_reg, hwrite_reg_1, temp_sel, err_resp, err_ready
    );

    modport slave (
        input  hready_in, htrans, hwrite, haddr, hwdata,
        output valid, haddr_0, haddr_1, hwdata_0, hwdata_1,
               hwrite_reg, hwrite_reg_1, temp_sel, err_resp, err_ready
    );
endinterface
`default_nettype wire

// File: rtl/ahb_slave_if.sv
`default_nettype none
// ============================================================================
// Module      : ahb_slave_if
// Description : AHB-Lite slave front end of the AHB-to-APB bridge. Registers
//               the address/data/control pipeline in two stages, decodes a
//               one-hot APB slave select from a three-region address map and
//               produces the valid qualifier for the bridge FSM. Transfers to
//               unmapped addresses get a local two-cycle ERROR response.
// Ports       : hclk    - bus clock, rising edge
//               hresetn - asynchronous active-low reset
//               bus     - ahb_slave_if_if.slave (AHB inputs, pipeline
//                         outputs, slave select, error response)
// Revision    : 1.0  initial release
// ============================================================================
module ahb_slave_if #(
    parameter logic [31:0] BASE0       = 32'h8000_0000,
    parameter logic [31:0] BASE1       = 32'h8400_0000,
    parameter logic [31:0] BASE2       = 32'h8800_0000,
    parameter int          REGION_BITS = 26
) (
    input  wire logic      hclk,
    input  wire logic      hresetn,
    ahb_slave_if_if.slave  bus
);

    typedef enum logic [1:0] {
        ERR_IDLE = 2'd0,
        ERR_CYC1 = 2'd1,
        ERR_CYC2 = 2'd2
    } err_state_t;

    err_state_t  r_err_state;
    err_state_t  w_err_next;
    logic [1:0]  w_err_resp;
    logic        w_err_ready;

    logic [2:0]  w_sel_d;
    logic        w_active;

    logic [31:0] r_haddr_0;
    logic [31:0] r_haddr_1;
    logic [31:0] r_hwdata_0;
    logic [31:0] r_hwdata_1;
    logic        r_hwrite_reg;
    logic        r_hwrite_reg_1;
    logic [2:0]  r_temp_sel;

    // Address decode: each region is 2**REGION_BITS bytes, so only the bits
    // above the region size take part in the match.
    always_comb begin
        w_sel_d = 3'b000;
        if (bus.haddr[31:REGION_BITS] == BASE0[31:REGION_BITS])
            w_sel_d = 3'b001;
        else if (bus.haddr[31:REGION_BITS] == BASE1[31:REGION_BITS])
            w_sel_d = 3'b010;
        else if (bus.haddr[31:REGION_BITS] == BASE2[31:REGION_BITS])
            w_sel_d = 3'b100;
    end

    // NONSEQ and SEQ both have htrans[1] set; IDLE and BUSY do not.
    assign w_active = bus.htrans[1];

    // The explicit hresetn term keeps valid low for the whole reset interval,
    // not just after the FSM has been forced to ERR_IDLE.
    assign bus.valid = hresetn & bus.hready_in & w_active &
                       (w_sel_d != 3'b000) & (r_err_state == ERR_IDLE);

    // Two-stage address/data/control pipeline, advancing only on HREADY.
    // Unmapped transfers shift through too; temp_sel = 000 flags them.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_haddr_0      <= 32'h0;
            r_haddr_1      <= 32'h0;
            r_hwdata_0     <= 32'h0;
            r_hwdata_1     <= 32'h0;
            r_hwrite_reg   <= 1'b0;
            r_hwrite_reg_1 <= 1'b0;
            r_temp_sel     <= 3'b000;
        end else if (bus.hready_in) begin
            r_haddr_1      <= r_haddr_0;
            r_haddr_0      <= bus.haddr;
            r_hwdata_1     <= r_hwdata_0;
            r_hwdata_0     <= bus.hwdata;
            r_hwrite_reg_1 <= r_hwrite_reg;
            r_hwrite_reg   <= bus.hwrite;
            r_temp_sel     <= w_sel_d;
        end
    end

    assign bus.haddr_0      = r_haddr_0;
    assign bus.haddr_1      = r_haddr_1;
    assign bus.hwdata_0     = r_hwdata_0;
    assign bus.hwdata_1     = r_hwdata_1;
    assign bus.hwrite_reg   = r_hwrite_reg;
    assign bus.hwrite_reg_1 = r_hwrite_reg_1;
    assign bus.temp_sel     = r_temp_sel;

    // Error responder state register
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn)
            r_err_state <= ERR_IDLE;
        else
            r_err_state <= w_err_next;
    end

    // Two-cycle AHB ERROR: first cycle with HREADYOUT low, second with it
    // high. A transfer presented during the second cycle is dropped.
    always_comb begin
        w_err_next  = r_err_state;
        w_err_resp  = 2'b00;
        w_err_ready = 1'b1;
        case (r_err_state)
            ERR_IDLE: begin
                if (bus.hready_in && w_active && (w_sel_d == 3'b000))
                    w_err_next = ERR_CYC1;
            end
            ERR_CYC1: begin
                w_err_resp  = 2'b01;
                w_err_ready = 1'b0;
                w_err_next  = ERR_CYC2;
            end
            ERR_CYC2: begin
                w_err_resp  = 2'b01;
                w_err_ready = 1'b1;
                w_err_next  = ERR_IDLE;
            end
            default: begin
                w_err_next = ERR_IDLE;
            end
        endcase
    end

    assign bus.err_resp  = w_err_resp;
    assign bus.err_ready = w_err_ready;

endmodule
`default_nettype wire

// File: tb/tb_ahb_slave_if.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahb_slave_if
// Description : Self-checking bench for ahb_slave_if. Directed scenarios are
//               checked against literal expectations; a randomized run is
//               checked against a transaction-level reference model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_ahb_slave_if;

    logic hclk    = 1'b0;
    logic hresetn = 1'b0;
    int   n_vec   = 0;
    int   n_err   = 0;

    ahb_slave_if_if bus ();

    ahb_slave_if dut (
        .hclk    (hclk),
        .hresetn (hresetn),
        .bus     (bus)
    );

    always #5 hclk = ~hclk;

    // ------------------------------------------------------------------
    // Reference model: the pipeline outputs are simply the last and the
    // second-to-last values seen in accepted (hready_in=1) cycles; the error
    // responder is a countdown of remaining error cycles.
    // ------------------------------------------------------------------
    logic [31:0] m_a0, m_a1, m_d0, m_d1;
    logic        m_w0, m_w1;
    logic [2:0]  m_sel;
    int unsigned m_err_left;

    function automatic logic [2:0] ref_sel(input logic [31:0] a);
        int unsigned region;
        region = a / 32'h0400_0000;          // 64 MiB regions
        if (region == 32)      return 3'b001;
        else if (region == 33) return 3'b010;
        else if (region == 34) return 3'b100;
        else                   return 3'b000;
    endfunction

    always @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            m_a0 <= '0; m_a1 <= '0; m_d0 <= '0; m_d1 <= '0;
            m_w0 <= 1'b0; m_w1 <= 1'b0; m_sel <= 3'b000;
            m_err_left <= 0;
        end else begin
            if (bus.hready_in) begin
                m_a1 <= m_a0; m_a0 <= bus.haddr;
                m_d1 <= m_d0; m_d0 <= bus.hwdata;
                m_w1 <= m_w0; m_w0 <= bus.hwrite;
                m_sel <= ref_sel(bus.haddr);
            end
            if (m_err_left != 0)
                m_err_left <= m_err_left - 1;
            else if (bus.hready_in && bus.htrans[1] && ref_sel(bus.haddr) == 3'b000)
                m_err_left <= 2;
        end
    end

    task automatic drive(input logic rdy, input logic [1:0] tr, input logic wr,
                         input logic [31:0] a, input logic [31:0] d);
        bus.hready_in = rdy;
        bus.htrans    = tr;
        bus.hwrite    = wr;
        bus.haddr     = a;
        bus.hwdata    = d;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge hclk);
            drive(1'b1, 2'($urandom_range(0, 3)), 1'($urandom), $urandom, $urandom);
        end
        @(posedge hclk);
        #2;
        hresetn = 1'b0;
        drive(1'b1, 2'b10, 1'b1, 32'h8000_0000, 32'h1234_5678);
        #1;
        n_vec++; if (bus.haddr_0 !== 32'h0)  begin n_err++; $display("FAIL reset_haddr_0 got %h exp 0", bus.haddr_0); end
        n_vec++; if (bus.haddr_1 !== 32'h0)  begin n_err++; $display("FAIL reset_haddr_1 got %h exp 0", bus.haddr_1); end
        n_vec++; if (bus.hwdata_0 !== 32'h0) begin n_err++; $display("FAIL reset_hwdata_0 got %h exp 0", bus.hwdata_0); end
        n_vec++; if (bus.hwdata_1 !== 32'h0) begin n_err++; $display("FAIL reset_hwdata_1 got %h exp 0", bus.hwdata_1); end
        n_vec++; if ({bus.hwrite_reg, bus.hwrite_reg_1} !== 2'b00)
            begin n_err++; $display("FAIL reset_hwrite got %b exp 00", {bus.hwrite_reg, bus.hwrite_reg_1}); end
        n_vec++; if (bus.temp_sel !== 3'b000) begin n_err++; $display("FAIL reset_temp_sel got %b exp 000", bus.temp_sel); end
        n_vec++; if (bus.err_resp !== 2'b00)  begin n_err++; $display("FAIL reset_err_resp got %b exp 00", bus.err_resp); end
        n_vec++; if (bus.err_ready !== 1'b1)  begin n_err++; $display("FAIL reset_err_ready got %b exp 1", bus.err_ready); end
        n_vec++; if (bus.valid !== 1'b0)      begin n_err++; $display("FAIL reset_valid got %b exp 0", bus.valid); end
        @(negedge hclk);
        drive(1'b1, 2'b00, 1'b0, 32'h0, 32'h0);
        hresetn = 1'b1;
    endtask

    task automatic test_single_write();
        @(negedge hclk);
        drive(1'b1, 2'b10, 1'b1, 32'h8400_0010, $urandom);
        #1;
        n_vec++; if (bus.valid !== 1'b1) begin n_err++; $display("FAIL wr_valid got %b exp 1", bus.valid); end
        @(negedge hclk);
        drive(1'b1, 2'b00, 1'b0, 32'h0, 32'hDEAD_BEEF);
        #1;
        n_vec++; if (bus.haddr_0 !== 32'h8400_0010) begin n_err++; $display("FAIL wr_haddr_0 got %h exp 84000010", bus.haddr_0); end
        n_vec++; if (bus.temp_sel !== 3'b010)       begin n_err++; $display("FAIL wr_temp_sel got %b exp 010", bus.temp_sel); end
        n_vec++; if (bus.hwrite_reg !== 1'b1)       begin n_err++; $display("FAIL wr_hwrite_reg got %b exp 1", bus.hwrite_reg); end
        @(negedge hclk);
        drive(1'b1, 2'b00, 1'b0, 32'h0, 32'h0);
        #1;
        n_vec++; if (bus.hwdata_0 !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL wr_hwdata_0 got %h exp deadbeef", bus.hwdata_0); end
        n_vec++; if (bus.haddr_1 !== 32'h8400_0010)  begin n_err++; $display("FAIL wr_haddr_1 got %h exp 84000010", bus.haddr_1); end
        n_vec++; if (bus.hwrite_reg_1 !== 1'b1)      begin n_err++; $display("FAIL wr_hwrite_reg_1 got %b exp 1", bus.hwrite_reg_1); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [3];
        logic [2:0]  sels  [3];
        addrs[0] = 32'h8000_0000; addrs[1] = 32'h8800_0004; addrs[2] = 32'h8000_0008;
        sels[0]  = 3'b001;        sels[1]  = 3'b100;        sels[2]  = 3'b001;
        for (int i = 0; i < 4; i++) begin
            @(negedge hclk);
            if (i < 3) drive(1'b1, 2'b10, 1'b0, addrs[i], 32'h0);
            else       drive(1'b1, 2'b00, 1'b0, 32'h0, 32'h0);
            #1;
            if (i < 3) begin
                n_vec++; if (bus.valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid[%0d] got %b exp 1", i, bus.valid); end
            end
            if (i > 0) begin
                n_vec++; if (bus.temp_sel !== sels[i-1])
                    begin n_err++; $display("FAIL b2b_temp_sel[%0d] got %b exp %b", i, bus.temp_sel, sels[i-1]); end
                n_vec++; if (bus.haddr_0 !== addrs[i-1])
                    begin n_err++; $display("FAIL b2b_haddr_0[%0d] got %h exp %h", i, bus.haddr_0, addrs[i-1]); end
            end
            if (i > 1) begin
                n_vec++; if (bus.haddr_1 !== addrs[i-2])
                    begin n_err++; $display("FAIL b2b_haddr_1[%0d] got %h exp %h", i, bus.haddr_1, addrs[i-2]); end
            end
        end
    endtask

    task automatic test_stall();
        @(negedge hclk);
        drive(1'b1, 2'b00, 1'b0, 32'h8000_0010, 32'h0);
        @(negedge hclk);
        drive(1'b1, 2'b10, 1'b0, 32'h8000_0020, 32'h0);
        #1;
        n_vec++; if (bus.valid !== 1'b1) begin n_err++; $display("FAIL stall_first_valid got %b exp 1", bus.valid); end
        for (int k = 0; k < 3; k++) begin
            @(negedge hclk);
            drive(1'b0, 2'b10, 1'b0, 32'h8800_0000, $urandom);
            #1;
            n_vec++; if (bus.valid !== 1'b0) begin n_err++; $display("FAIL stall_valid[%0d] got %b exp 0", k, bus.valid); end
            n_vec++; if (bus.haddr_0 !== 32'h8000_0020)
                begin n_err++; $display("FAIL stall_haddr_0[%0d] got %h exp 80000020", k, bus.haddr_0); end
            n_vec++; if (bus.haddr_1 !== 32'h8000_0010)
                begin n_err++; $display("FAIL stall_haddr_1[%0d] got %h exp 80000010", k, bus.haddr_1); end
            n_vec++; if (bus.temp_sel !== 3'b001)
                begin n_err++; $display("FAIL stall_temp_sel[%0d] got %b exp 001", k, bus.temp_sel); end
        end
        @(negedge hclk);
        drive(1'b1, 2'b10, 1'b0, 32'h8800_0000, 32'h0);
        #1;
        n_vec++; if (bus.valid !== 1'b1) begin n_err++; $display("FAIL stall_release_valid got %b exp 1", bus.valid); end
        @(negedge hclk);
        drive(1'b1, 2'b00, 1'b0, 32'h0, 32'h0);
        #1;
        n_vec++; if (bus.haddr_0 !== 32'h8800_0000) begin n_err++; $display("FAIL stall_after_haddr_0 got %h exp 88000000", bus.haddr_0); end
        n_vec++; if (bus.haddr_1 !== 32'h8000_0020) begin n_err++; $display("FAIL stall_after_haddr_1 got %h exp 80000020", bus.haddr_1); end
        n_vec++; if (bus.temp_sel !== 3'b100)       begin n_err++; $display("FAIL stall_after_temp_sel got %b exp 100", bus.temp_sel); end
    endtask

    task automatic test_unmapped();
        @(negedge hclk);
        drive(1'b1, 2'b10, 1'b0, 32'h9000_0000, 32'h0);
        #1;
        n_vec++; if (bus.valid !== 1'b0)     begin n_err++; $display("FAIL unm_valid got %b exp 0", bus.valid); end
        n_vec++; if (bus.err_resp !== 2'b00) begin n_err++; $display("FAIL unm_resp0 got %b exp 00", bus.err_resp); end
        @(negedge hclk);
        drive(1'b1, 2'b00, 1'b0, 32'h0, 32'h0);
        #1;
        n_vec++; if (bus.err_resp !== 2'b01)  begin n_err++; $display("FAIL unm_resp1 got %b exp 01", bus.err_resp); end
        n_vec++; if (bus.err_ready !== 1'b0)  begin n_err++; $display("FAIL unm_ready1 got %b exp 0", bus.err_ready); end
        n_vec++; if (bus.temp_sel !== 3'b000) begin n_err++; $display("FAIL unm_temp_sel got %b exp 000", bus.temp_sel); end
        @(negedge hclk);
        drive(1'b1, 2'b10, 1'b0, 32'h8000_0000, 32'h0);
        #1;
        n_vec++; if (bus.err_resp !== 2'b01) begin n_err++; $display("FAIL unm_resp2 got %b exp 01", bus.err_resp); end
        n_vec++; if (bus.err_ready !== 1'b1) begin n_err++; $display("FAIL unm_ready2 got %b exp 1", bus.err_ready); end
        n_vec++; if (bus.valid !== 1'b0)     begin n_err++; $display("FAIL unm_cyc2_valid got %b exp 0", bus.valid); end
        @(negedge hclk);
        drive(1'b1, 2'b10, 1'b0, 32'h8000_0000, 32'h0);
        #1;
        n_vec++; if (bus.err_resp !== 2'b00) begin n_err++; $display("FAIL unm_resp3 got %b exp 00", bus.err_resp); end
        n_vec++; if (bus.valid !== 1'b1)     begin n_err++; $display("FAIL unm_next_valid got %b exp 1", bus.valid); end
    endtask

    task automatic test_busy_idle();
        logic [1:0] tr [2];
        tr[0] = 2'b01; tr[1] = 2'b00;
        for (int i = 0; i < 2; i++) begin
            @(negedge hclk);
            drive(1'b1, tr[i], 1'b0, 32'h8000_0000, 32'h0);
            #1;
            n_vec++; if (bus.valid !== 1'b0)
                begin n_err++; $display("FAIL busyidle_valid[%0d] got %b exp 0", i, bus.valid); end
            n_vec++; if (bus.err_resp !== 2'b00 || bus.err_ready !== 1'b1)
                begin n_err++; $display("FAIL busyidle_err[%0d] got %b/%b exp 00/1", i, bus.err_resp, bus.err_ready); end
        end
        // Also an unmapped BUSY must not raise an error.
        @(negedge hclk);
        drive(1'b1, 2'b01, 1'b0, 32'h9000_0000, 32'h0);
        @(negedge hclk);
        drive(1'b1, 2'b00, 1'b0, 32'h0, 32'h0);
        #1;
        n_vec++; if (bus.err_resp !== 2'b00)
            begin n_err++; $display("FAIL busy_unmapped_err got %b exp 00", bus.err_resp); end
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic        exp_valid;
        for (int i = 0; i < 400; i++) begin
            @(negedge hclk);
            case ($urandom_range(0, 4))
                0:       a = 32'h8000_0000 + $urandom_range(0, 32'h03FF_FFFF);
                1:       a = 32'h8400_0000 + $urandom_range(0, 32'h03FF_FFFF);
                2:       a = 32'h8800_0000 + $urandom_range(0, 32'h03FF_FFFF);
                3:       a = 32'h8C00_0000 + $urandom_range(0, 32'h03FF_FFFF);
                default: a = $urandom;
            endcase
            drive(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 1'($urandom), a, $urandom);
            #1;
            exp_valid = bus.hready_in && bus.htrans[1] && ref_sel(a) != 3'b000 && m_err_left == 0;
            n_vec++; if (bus.valid !== exp_valid)
                begin n_err++; $display("FAIL rnd_valid[%0d] got %b exp %b", i, bus.valid, exp_valid); end
            n_vec++; if (bus.haddr_0 !== m_a0 || bus.haddr_1 !== m_a1)
                begin n_err++; $display("FAIL rnd_haddr[%0d] got %h/%h exp %h/%h", i, bus.haddr_0, bus.haddr_1, m_a0, m_a1); end
            n_vec++; if (bus.hwdata_0 !== m_d0 || bus.hwdata_1 !== m_d1)
                begin n_err++; $display("FAIL rnd_hwdata[%0d] got %h/%h exp %h/%h", i, bus.hwdata_0, bus.hwdata_1, m_d0, m_d1); end
            n_vec++; if (bus.hwrite_reg !== m_w0 || bus.hwrite_reg_1 !== m_w1)
                begin n_err++; $display("FAIL rnd_hwrite[%0d] got %b/%b exp %b/%b", i, bus.hwrite_reg, bus.hwrite_reg_1, m_w0, m_w1); end
            n_vec++; if (bus.temp_sel !== m_sel)
                begin n_err++; $display("FAIL rnd_temp_sel[%0d] got %b exp %b", i, bus.temp_sel, m_sel); end
            n_vec++; if (bus.err_resp !== ((m_err_left != 0) ? 2'b01 : 2'b00))
                begin n_err++; $display("FAIL rnd_err_resp[%0d] got %b left %0d", i, bus.err_resp, m_err_left); end
            n_vec++; if (bus.err_ready !== (m_err_left != 2))
                begin n_err++; $display("FAIL rnd_err_ready[%0d] got %b left %0d", i, bus.err_ready, m_err_left); end
        end
    endtask

    initial begin
        drive(1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        hresetn = 1'b0;
        repeat (2) @(negedge hclk);
        hresetn = 1'b1;
        test_reset();
        test_single_write();
        test_back_to_back();
        test_stall();
        test_unmapped();
        test_busy_idle();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
